// File: rtl/dmem_pkg.sv
// Shared types, address-map constants and access helpers for the data-memory responder.
package dmem_pkg;

    // Access size as encoded on the mask port.
    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } size_e;

    // What the registered response stage presents on rdata.
    typedef enum logic [1:0] {
        RESP_ZERO = 2'b00,
        RESP_RAM  = 2'b01,
        RESP_MMIO = 2'b10
    } resp_e;

    // Timer register selected by addr[3:2] inside the MMIO page.
    typedef enum logic [1:0] {
        REG_MTIME_LO    = 2'b00,
        REG_MTIME_HI    = 2'b01,
        REG_MTIMECMP_LO = 2'b10,
        REG_MTIMECMP_HI = 2'b11
    } mmio_reg_e;

    // Window bases compared against addr[31:16].
    localparam logic [15:0] RAM_BASE_HI_DEFAULT  = 16'h8000;
    localparam logic [15:0] MMIO_BASE_HI_DEFAULT = 16'h1000;

    // Byte offsets of the timer registers within the MMIO page.
    localparam logic [15:0] MMIO_MTIME_LO    = 16'h0000;
    localparam logic [15:0] MMIO_MTIME_HI    = 16'h0004;
    localparam logic [15:0] MMIO_MTIMECMP_LO = 16'h0008;
    localparam logic [15:0] MMIO_MTIMECMP_HI = 16'h000C;

    // True when the size/offset pair cannot be served (includes the reserved size).
    function automatic logic misaligned(input size_e size, input logic [1:0] off);
        logic bad;
        case (size)
            BYTE:    bad = 1'b0;
            HALF:    bad = off[0];
            WORD:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Byte lanes touched by a store of the given size at the given offset.
    function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
        logic [3:0] lanes;
        case (size)
            BYTE:    lanes = 4'b0001 << off;
            HALF:    lanes = 4'b0011 << off;
            WORD:    lanes = 4'b1111;
            default: lanes = 4'b0000;
        endcase
        return lanes;
    endfunction

    // Right-align the addressed bytes of a RAM word and clear everything above the size.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input size_e size,
                                                 input logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (size)
            BYTE:    res = {24'd0, sh[7:0]};
            HALF:    res = {16'd0, sh[15:0]};
            WORD:    res = sh;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Machine timer: free-running 64-bit mtime, 64-bit mtimecmp and the registered compare level.
module dmem_timer
    import dmem_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  mmio_reg_e   wr_sel,
    input  logic [31:0] wr_data,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        timer_irq
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        irq_q, irq_d;

    // Next timer state: count every cycle unless a half of mtime is being written;
    // the compare looks at the values that will be in the registers after this edge.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (wr_en) begin
            case (wr_sel)
                REG_MTIME_LO:    mtime_d = {mtime_q[63:32], wr_data};
                REG_MTIME_HI:    mtime_d = {wr_data, mtime_q[31:0]};
                REG_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], wr_data};
                REG_MTIMECMP_HI: mtimecmp_d = {wr_data, mtimecmp_q[31:0]};
                default:         mtime_d = mtime_q + 64'd1;
            endcase
        end
        irq_d = (mtime_d >= mtimecmp_d);
    end

    // Timer registers; mtimecmp comes out of reset at its maximum so no interrupt fires.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= irq_d;
        end
    end

    assign mtime     = mtime_q;
    assign mtimecmp  = mtimecmp_q;
    assign timer_irq = irq_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM window plus timer MMIO page, fixed one-cycle load latency.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 16384,
    parameter logic [15:0] RAM_BASE_HI  = RAM_BASE_HI_DEFAULT,
    parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        wen,
    input  logic [31:0] wdata,
    input  logic [1:0]  mask,
    input  logic        hold,
    output logic [31:0] rdata,
    output logic        err,
    output logic        timer_irq
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    // Request decode
    size_e          req_size;
    logic [1:0]     req_off;
    logic [31:0]    word_off;
    logic           in_ram;
    logic           in_mmio;
    logic           mmio_off_ok;
    logic           ram_hit;
    logic           mmio_hit;
    logic           req_ok;
    logic [AW-1:0]  ram_idx;
    logic [3:0]     lanes;
    logic [31:0]    wdata_sh;
    logic           ram_we;
    logic           ram_re;
    logic           tmr_we;

    // RAM storage and its read register
    logic [31:0]    mem [DEPTH_WORDS];
    logic [31:0]    ram_word_q;

    // Timer interface
    logic [63:0]    mtime;
    logic [63:0]    mtimecmp;
    logic [31:0]    mmio_rdata;

    // Response stage
    resp_e          resp_q, resp_d;
    logic           err_q, err_d;
    size_e          size_q, size_d;
    logic [1:0]     off_q, off_d;
    logic [31:0]    mmio_rd_q, mmio_rd_d;

    // Classify the current request: which window it hits and whether it is legal there.
    always_comb begin
        req_size    = size_e'(mask);
        req_off     = addr[1:0];
        word_off    = {18'd0, addr[15:2]};
        ram_idx     = addr[AW+1:2];
        in_ram      = (addr[31:16] == RAM_BASE_HI) && (word_off < DEPTH_WORDS);
        in_mmio     = (addr[31:16] == MMIO_BASE_HI);
        mmio_off_ok = addr[15:0] inside {MMIO_MTIME_LO, MMIO_MTIME_HI,
                                         MMIO_MTIMECMP_LO, MMIO_MTIMECMP_HI};
        ram_hit     = in_ram && !misaligned(req_size, req_off);
        mmio_hit    = !in_ram && in_mmio && (req_size == WORD) && mmio_off_ok;
        req_ok      = ram_hit || mmio_hit;
        lanes       = lane_mask(req_size, req_off);
        wdata_sh    = wdata << {req_off, 3'b000};
    end

    // Access strobes; reset (active low) also blocks the RAM write so a store caught
    // by a reset assertion in the same cycle is dropped rather than committed.
    always_comb begin
        ram_we = !hold && wen && ram_hit && reset;
        ram_re = !hold && !wen && ram_hit;
        tmr_we = !hold && wen && mmio_hit;
    end

    // Byte-lane RAM with a registered read port; contents are never reset.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (ram_we && lanes[i]) begin
                mem[ram_idx][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
        if (ram_re) begin
            ram_word_q <= mem[ram_idx];
        end
    end

    dmem_timer u_timer (
        .clock     (clock),
        .reset     (reset),
        .wr_en     (tmr_we),
        .wr_sel    (mmio_reg_e'(addr[3:2])),
        .wr_data   (wdata),
        .mtime     (mtime),
        .mtimecmp  (mtimecmp),
        .timer_irq (timer_irq)
    );

    // Timer register read mux, sampled into the response stage on MMIO loads.
    always_comb begin
        case (mmio_reg_e'(addr[3:2]))
            REG_MTIME_LO:    mmio_rdata = mtime[31:0];
            REG_MTIME_HI:    mmio_rdata = mtime[63:32];
            REG_MTIMECMP_LO: mmio_rdata = mtimecmp[31:0];
            REG_MTIMECMP_HI: mmio_rdata = mtimecmp[63:32];
            default:         mmio_rdata = '0;
        endcase
    end

    // Next response: a held cycle keeps everything; otherwise record what the
    // output must show one cycle later (zero for stores and errors).
    always_comb begin
        resp_d    = resp_q;
        err_d     = err_q;
        size_d    = size_q;
        off_d     = off_q;
        mmio_rd_d = mmio_rd_q;
        if (!hold) begin
            err_d  = !req_ok;
            size_d = req_size;
            off_d  = req_off;
            resp_d = RESP_ZERO;
            if (ram_hit && !wen) begin
                resp_d = RESP_RAM;
            end else if (mmio_hit && !wen) begin
                resp_d    = RESP_MMIO;
                mmio_rd_d = mmio_rdata;
            end
        end
    end

    // Response registers; reset forces the output side to zero immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            resp_q    <= RESP_ZERO;
            err_q     <= 1'b0;
            size_q    <= BYTE;
            off_q     <= '0;
            mmio_rd_q <= '0;
        end else begin
            resp_q    <= resp_d;
            err_q     <= err_d;
            size_q    <= size_d;
            off_q     <= off_d;
            mmio_rd_q <= mmio_rd_d;
        end
    end

    // Load alignment is applied after the RAM read register so the array stays a
    // plain synchronous block RAM; the stage registers select and shape its word.
    always_comb begin
        case (resp_q)
            RESP_RAM:  rdata = load_extract(ram_word_q, size_q, off_q);
            RESP_MMIO: rdata = mmio_rd_q;
            default:   rdata = '0;
        endcase
        err = err_q;
    end

endmodule
